// File: rtl/lsu_sized.sv
// rtl/lsu_sized.sv - sized RV32I load/store unit with data RAM window and memory-mapped IO
//
// Purpose: services one load or store per cycle (B/H/W, signed/unsigned)
// against a parametrised data RAM window and a small set of IO registers.
// Every accepted request is answered by a single-cycle ack on the next cycle.
//
// Parameters:
//   RAM_BASE   byte base of the data RAM, aligned to the RAM region size
//   RAM_WORDS  RAM depth in 32-bit words, power of two, 16..8192
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   i_req, i_we            access request, 1 = store / 0 = load
//   i_funct3               RV32I size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   i_addr, i_wdata        byte address (bits 31:16 ignored), right-aligned store data
//   o_ack, o_err, o_rdata  response: ack pulse, misaligned/illegal flag, load data
//   o_io_ledr, o_io_ledg   LED registers
//   o_io_hex0..o_io_hex7   seven-segment digit registers
//   o_io_lcd               LCD register
//   i_io_sw, i_io_btn      switch and button inputs
//
// Build option: LSU_SYNC_EN adds 2-flop synchronizers on i_io_sw and i_io_btn.

module lsu_sized #(
    parameter logic [31:0] RAM_BASE  = 32'h0000_2000,
    parameter int          RAM_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn
);

    localparam int AW = $clog2(RAM_WORDS);

    // Upper address bits take no part in decode.
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_addr[31:16];

    // ---------------------------------------------------------------
    // Switch / button sampling
    // ---------------------------------------------------------------
    logic [31:0] sw_s;
    logic [3:0]  btn_s;

`ifdef LSU_SYNC_EN
    logic [31:0] sw_m;
    logic [3:0]  btn_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_m  <= '0;
            sw_s  <= '0;
            btn_m <= '0;
            btn_s <= '0;
        end else begin
            sw_m  <= i_io_sw;
            sw_s  <= sw_m;
            btn_m <= i_io_btn;
            btn_s <= btn_m;
        end
    end
`else
    assign sw_s  = i_io_sw;
    assign btn_s = i_io_btn;
`endif

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic [13:0]   widx;
    logic [1:0]    lane;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          sel_ledr, sel_ledg, sel_hexlo, sel_hexhi, sel_lcd, sel_sw, sel_btn;

    assign widx    = i_addr[15:2];
    assign lane    = i_addr[1:0];
    assign ram_idx = i_addr[AW+1:2];
    // RAM_BASE is aligned to the region size, so a prefix compare suffices.
    assign ram_hit = (i_addr[15:AW+2] == RAM_BASE[15:AW+2]);

    // RAM wins if a strange RAM_BASE ever overlaps the IO page.
    assign sel_ledr  = !ram_hit && (widx == 14'h1C00);
    assign sel_ledg  = !ram_hit && (widx == 14'h1C04);
    assign sel_hexlo = !ram_hit && (widx == 14'h1C08);
    assign sel_hexhi = !ram_hit && (widx == 14'h1C09);
    assign sel_lcd   = !ram_hit && (widx == 14'h1C0C);
    assign sel_sw    = !ram_hit && (widx == 14'h1E00);
    assign sel_btn   = !ram_hit && (widx == 14'h1E04);

    // ---------------------------------------------------------------
    // Legality, byte enables and lane-replicated write data
    // ---------------------------------------------------------------
    logic        bad;
    logic [3:0]  be;
    logic [31:0] wrep;
    logic        do_wr, do_rd;

    always_comb begin
        bad = 1'b0;
        case (i_funct3)
            3'b001, 3'b101:         bad = i_addr[0];
            3'b010:                 bad = |i_addr[1:0];
            3'b011, 3'b110, 3'b111: bad = 1'b1;
            default:                bad = 1'b0;
        endcase
    end

    always_comb begin
        be   = 4'b1111;
        wrep = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                be   = 4'b0001 << lane;
                wrep = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be   = 4'b0011 << lane;
                wrep = {2{i_wdata[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = i_wdata;
            end
        endcase
    end

    assign do_wr = i_req &&  i_we && !bad;
    assign do_rd = i_req && !i_we && !bad;

    function automatic logic [31:0] merge(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  en);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (en[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // ---------------------------------------------------------------
    // Data RAM: byte-enabled write, registered read, no reset
    // ---------------------------------------------------------------
    logic [31:0] mem [RAM_WORDS];
    logic [31:0] ram_q;

    always_ff @(posedge clk) begin
        if (do_wr && ram_hit)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[ram_idx][8*b +: 8] <= wrep[8*b +: 8];
        if (do_rd && ram_hit)
            ram_q <= mem[ram_idx];
    end

    // ---------------------------------------------------------------
    // IO registers
    // ---------------------------------------------------------------
    logic [31:0] ledr, ledg, hex_lo, hex_hi, lcd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr   <= '0;
            ledg   <= '0;
            hex_lo <= '0;
            hex_hi <= '0;
            lcd    <= '0;
        end else if (do_wr) begin
            if (sel_ledr)  ledr   <= merge(ledr, wrep, be);
            if (sel_ledg)  ledg   <= merge(ledg, wrep, be);
            // Segment bytes carry 7 bits; bit 7 of each byte is never stored.
            if (sel_hexlo) hex_lo <= merge(hex_lo, wrep, be) & 32'h7F7F_7F7F;
            if (sel_hexhi) hex_hi <= merge(hex_hi, wrep, be) & 32'h7F7F_7F7F;
            if (sel_lcd)   lcd    <= merge(lcd, wrep, be);
        end
    end

    assign o_io_ledr = ledr;
    assign o_io_ledg = ledg;
    assign o_io_lcd  = lcd;
    assign o_io_hex0 = hex_lo[6:0];
    assign o_io_hex1 = hex_lo[14:8];
    assign o_io_hex2 = hex_lo[22:16];
    assign o_io_hex3 = hex_lo[30:24];
    assign o_io_hex4 = hex_hi[6:0];
    assign o_io_hex5 = hex_hi[14:8];
    assign o_io_hex6 = hex_hi[22:16];
    assign o_io_hex7 = hex_hi[30:24];

    logic [31:0] io_word;

    always_comb begin
        io_word = '0;
        if (sel_ledr)  io_word = ledr;
        if (sel_ledg)  io_word = ledg;
        if (sel_hexlo) io_word = hex_lo;
        if (sel_hexhi) io_word = hex_hi;
        if (sel_lcd)   io_word = lcd;
        if (sel_sw)    io_word = sw_s;
        if (sel_btn)   io_word = {28'd0, btn_s};
    end

    // ---------------------------------------------------------------
    // Response stage
    // ---------------------------------------------------------------
    logic        ack_q, err_q, rd_q, src_ram_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [31:0] io_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_q      <= 1'b0;
            src_ram_q <= 1'b0;
            f3_q      <= '0;
            lane_q    <= '0;
            io_q      <= '0;
        end else begin
            ack_q <= i_req;
            err_q <= i_req && bad;
            rd_q  <= do_rd;
            if (do_rd) begin
                src_ram_q <= ram_hit;
                f3_q      <= i_funct3;
                lane_q    <= lane;
                io_q      <= io_word;
            end
        end
    end

    logic [31:0] word, shifted;

    assign word    = src_ram_q ? ram_q : io_q;
    assign shifted = word >> {lane_q, 3'b000};

    always_comb begin
        o_rdata = '0;
        if (rd_q) begin
            case (f3_q)
                3'b000:  o_rdata = {{24{shifted[7]}},  shifted[7:0]};
                3'b001:  o_rdata = {{16{shifted[15]}}, shifted[15:0]};
                3'b010:  o_rdata = shifted;
                3'b100:  o_rdata = {24'd0, shifted[7:0]};
                3'b101:  o_rdata = {16'd0, shifted[15:0]};
                default: o_rdata = '0;
            endcase
        end
    end

    assign o_ack = ack_q;
    assign o_err = err_q;

endmodule
